pulse_seq_ctrl: RTL

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

---
 rtl/pulse_seq_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/pulse_seq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg
// Shared definitions for the pulse sequencer slice: the FSM state
// encoding and the default requester count / phase-length width.
// No ports; imported by pulse_seq_ctrl and rr_arbiter.
package pulse_seq_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_LW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The search begins one index
// above the previous winner and ascends with wrap-around.
// Ports:
//   req        - per-requester request vector
//   last_grant - index of the previous winner
//   grant      - one-hot selected requester, all zero when req is zero
module rr_arbiter
  import pulse_seq_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant
);

  logic          found;
  logic [IW-1:0] iv;

  // Two ascending passes: indices above the previous winner take
  // precedence, then the scan wraps to the indices at or below it.
  always_comb begin
    grant = '0;
    found = 1'b0;
    iv    = '0;
    for (int i = 0; i < NREQ; i++) begin
      iv = IW'(i);
      if (!found && req[iv] && (iv > last_grant)) begin
        grant[iv] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      iv = IW'(i);
      if (!found && req[iv] && (iv <= last_grant)) begin
        grant[iv] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl
// Grants one requester at a time and plays a two-phase pulse sequence
// for it: q1 for max(len,1) cycles, then q2 for the same length, then
// a single-cycle done strobe. All outputs come straight from flops.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   req      - per-requester level start request
//   len      - phase length, captured when the grant is made
//   abort    - ends the running sequence at the next edge
//   gnt      - one-hot owner of the running sequence
//   q1, q2   - first and second phase pulses
//   busy     - a sequence is in progress
//   done     - one-cycle completion strobe
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LW   = DEF_LW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   len,
  input  logic            abort,
  output logic [NREQ-1:0] gnt,
  output logic            q1,
  output logic            q2,
  output logic            busy,
  output logic            done
);

  localparam int IW = $clog2(NREQ);

  state_t            state, state_n;
  logic [LW-1:0]     cnt, cnt_n;
  logic [LW-1:0]     reload, reload_n;
  logic [IW-1:0]     last_grant, last_grant_n;
  logic [IW-1:0]     arb_idx;
  logic [IW-1:0]     iv;
  logic [NREQ-1:0]   arb_gnt;
  logic [NREQ-1:0]   gnt_n;
  logic              q1_n, q2_n, busy_n, done_n;
  logic [LW-1:0]     len_m1;

  // A zero length behaves like one, so the counter preload saturates at 0.
  assign len_m1 = (len == '0) ? '0 : len - 1'b1;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_gnt)
  );

  // Convert the arbiter's one-hot winner into an index for last_grant.
  always_comb begin
    arb_idx = '0;
    iv      = '0;
    for (int i = 0; i < NREQ; i++) begin
      iv = IW'(i);
      if (arb_gnt[iv]) arb_idx = iv;
    end
  end

  // State register together with the phase counter, the captured
  // reload length and the round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      reload     <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      reload     <= reload_n;
      last_grant <= last_grant_n;
    end
  end

  // Next-state logic. The length is captured once at grant so later
  // changes on len cannot stretch or shorten a running sequence. The
  // winner is recorded at grant time, so an abort keeps the rotation.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    reload_n     = reload;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (!abort && (req != '0)) begin
          state_n      = PH1;
          cnt_n        = len_m1;
          reload_n     = len_m1;
          last_grant_n = arb_idx;
        end
      end
      PH1: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = PH2;
          cnt_n   = reload;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PH2: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the flopped outputs line up
  // with the state they describe. gnt loads on the granting edge,
  // holds for the whole sequence and clears whenever IDLE is entered.
  always_comb begin
    q1_n   = (state_n == PH1);
    q2_n   = (state_n == PH2);
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    if (state_n == IDLE) begin
      gnt_n = '0;
    end else if (state == IDLE) begin
      gnt_n = arb_gnt;
    end else begin
      gnt_n = gnt;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt  <= '0;
      q1   <= 1'b0;
      q2   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      gnt  <= gnt_n;
      q1   <= q1_n;
      q2   <= q2_n;
      busy <= busy_n;
      done <= done_n;
    end
  end

endmodule
